regfile_reader: RTL and testbench

- Sequential read-side companion to the 32-bit write-enabled register bank.
- On a start command, walks a contiguous address range of the register file and streams each word out over a valid/ready interface.
- Snoops the register-file write port, so a word written on the same edge it is read is delivered with the new value.
- Used for debug dump and state readback beside the CPU datapath.

---
 rtl/regfile_reader_pkg.sv | 16 +
 rtl/reader_bypass_mux.sv | 37 +++
 rtl/regfile_reader.sv | 125 ++++++++++++
 tb/tb_regfile_reader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_reader_pkg.sv
// rtl/regfile_reader_pkg.sv - shared state encoding and default widths for the register-file reader
// Contents: state_t (IDLE/READ/HOLD/DONE) and default word, address and count widths.
package regfile_reader_pkg;

  localparam int WIDTH_DEFAULT       = 32;
  localparam int ADDR_WIDTH_DEFAULT  = 5;
  localparam int COUNT_WIDTH_DEFAULT = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/reader_bypass_mux.sv
// rtl/reader_bypass_mux.sv - selects the word captured by the reader (snooped write, zero force, or rf_rdata)
// Ports:
//   addr     - address being read this cycle
//   rf_rdata - combinational read data from the register file
//   wr_en, wr_addr, wr_data - snooped register-file write port
//   data     - selected word
// Macro READ_ZERO_FORCE_EN: when defined, address 0 always reads as zero.
module reader_bypass_mux #(
  parameter int width      = 32,
  parameter int addr_width = 5
) (
  input  logic [addr_width-1:0] addr,
  input  logic [width-1:0]      rf_rdata,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [width-1:0]      wr_data,
  output logic [width-1:0]      data
);

  always_comb begin
    data = rf_rdata;
`ifdef READ_ZERO_FORCE_EN
    // Address 0 mirrors the hardwired zero register; a write to it is discarded.
    if (addr == '0) begin
      data = '0;
    end else if (wr_en && (wr_addr == addr)) begin
      data = wr_data;
    end
`else
    // A write landing on the same edge as the read must be seen with its new value.
    if (wr_en && (wr_addr == addr)) begin
      data = wr_data;
    end
`endif
  end

endmodule

// File: rtl/regfile_reader.sv
// rtl/regfile_reader.sv - streams a contiguous register-file address range out over valid/ready
// Ports:
//   clk, reset_n            - clock (rising edge), asynchronous active-low reset
//   start, base_addr, count - dump request, sampled only in IDLE
//   rf_raddr, rf_rdata      - combinational register-file read port
//   wr_en, wr_addr, wr_data - snooped register-file write port
//   out_data, out_addr, out_valid, out_ready - registered output stream
//   busy, done              - busy outside IDLE, done pulses for one cycle at the end
// Macro READ_ZERO_FORCE_EN: see reader_bypass_mux.
module regfile_reader
  import regfile_reader_pkg::*;
#(
  parameter int width       = WIDTH_DEFAULT,
  parameter int addr_width  = ADDR_WIDTH_DEFAULT,
  parameter int count_width = COUNT_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [addr_width-1:0]  base_addr,
  input  logic [count_width-1:0] count,
  output logic [addr_width-1:0]  rf_raddr,
  input  logic [width-1:0]       rf_rdata,
  input  logic                   wr_en,
  input  logic [addr_width-1:0]  wr_addr,
  input  logic [width-1:0]       wr_data,
  output logic [width-1:0]       out_data,
  output logic [addr_width-1:0]  out_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  state_t                 state, state_next;
  logic [addr_width-1:0]  cur;
  logic [count_width-1:0] rem;
  logic [width-1:0]       captured;
  logic                   handshake;
  logic                   last_word;

  assign handshake = (state == ST_HOLD) && out_valid && out_ready;
  assign last_word = (rem == count_width'(1));

  // cur is always presented; outside READ the read data is simply ignored.
  assign rf_raddr = cur;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  reader_bypass_mux #(
    .width      (width),
    .addr_width (addr_width)
  ) u_bypass (
    .addr     (cur),
    .rf_rdata (rf_rdata),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .data     (captured)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (count == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: state_next = ST_HOLD;
      ST_HOLD: begin
        if (handshake) begin
          state_next = last_word ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur       <= '0;
      rem       <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (count != '0)) begin
            cur <= base_addr;
            rem <= count;
          end
        end
        ST_READ: begin
          out_data  <= captured;
          out_addr  <= cur;
          out_valid <= 1'b1;
        end
        ST_HOLD: begin
          if (handshake) begin
            out_valid <= 1'b0;
            rem       <= rem - count_width'(1);
            // Address wraps naturally at 2^addr_width.
            if (!last_word) begin
              cur <= cur + addr_width'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_reader.sv
// tb/tb_regfile_reader.sv - directed self-checking bench for regfile_reader
module tb_regfile_reader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [4:0]  base_addr;
  logic [5:0]  count;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] out_data;
  logic [4:0]  out_addr;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  int          n_checks;
  int          n_fail;

  regfile_reader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  assign rf_rdata = rf[rf_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [4:0] b, input logic [5:0] c);
    start     = 1'b1;
    base_addr = b;
    count     = c;
    step();
    start = 1'b0;
  endtask

  logic [31:0] exp_zero;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = i * 16 + 3;

    // Reset state
    step();
    step();
    check("rst_data",  out_data, 32'h0);
    check("rst_addr",  32'(out_addr), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_done",  32'(done), 32'h0);
    check("rst_raddr", 32'(rf_raddr), 32'h0);
    reset_n = 1'b1;
    step();

    // Basic dump: base 4, count 3, ready held high
    go(5'd4, 6'd3);
    check("b_busy", 32'(busy), 32'h1);
    check("b_v_early", 32'(out_valid), 32'h0);
    step();
    check("b_v0", 32'(out_valid), 32'h1);
    check("b_d0", out_data, 32'h43);
    check("b_a0", 32'(out_addr), 32'd4);
    step();
    check("b_gap0", 32'(out_valid), 32'h0);
    step();
    check("b_d1", out_data, 32'h53);
    check("b_a1", 32'(out_addr), 32'd5);
    step();
    check("b_gap1", 32'(out_valid), 32'h0);
    step();
    check("b_d2", out_data, 32'h63);
    check("b_a2", 32'(out_addr), 32'd6);
    step();
    check("b_done", 32'(done), 32'h1);
    check("b_done_v", 32'(out_valid), 32'h0);
    step();
    check("b_done_end", 32'(done), 32'h0);
    check("b_idle", 32'(busy), 32'h0);

    // Backpressure plus an ignored start while busy
    out_ready = 1'b0;
    go(5'd8, 6'd2);
    step();
    check("bp_v", 32'(out_valid), 32'h1);
    check("bp_d", out_data, 32'h83);
    start = 1'b1;
    base_addr = 5'd0;
    count = 6'd5;
    for (int i = 0; i < 5; i++) begin
      step();
      start = 1'b0;
      check("bp_hold_v", 32'(out_valid), 32'h1);
      check("bp_hold_d", out_data, 32'h83);
      check("bp_hold_a", 32'(out_addr), 32'd8);
    end
    out_ready = 1'b1;
    step();
    check("bp_accept", 32'(out_valid), 32'h0);
    step();
    check("bp_d1", out_data, 32'h93);
    check("bp_a1", 32'(out_addr), 32'd9);
    step();
    check("bp_done", 32'(done), 32'h1);
    step();
    check("bp_idle", 32'(busy), 32'h0);
    check("bp_nomore", 32'(out_valid), 32'h0);

    // Wrap 30,31,0,1 with a snooped write to 31
`ifdef READ_ZERO_FORCE_EN
    exp_zero = 32'h0;
`else
    exp_zero = 32'h3;
`endif
    go(5'd30, 6'd4);
    step();
    check("w_a30", 32'(out_addr), 32'd30);
    check("w_d30", out_data, 32'h1E3);
    step();
    wr_en   = 1'b1;
    wr_addr = 5'd31;
    wr_data = 32'hDEADBEEF;
    step();
    wr_en = 1'b0;
    check("w_a31", 32'(out_addr), 32'd31);
    check("w_snoop", out_data, 32'hDEADBEEF);
    step();
    step();
    check("w_a0", 32'(out_addr), 32'd0);
    check("w_d0", out_data, exp_zero);
    step();
    step();
    check("w_a1", 32'(out_addr), 32'd1);
    check("w_d1", out_data, 32'h13);
    step();
    check("w_done", 32'(done), 32'h1);
    step();

    // Zero count
    go(5'd3, 6'd0);
    check("z_done", 32'(done), 32'h1);
    check("z_busy", 32'(busy), 32'h1);
    check("z_valid", 32'(out_valid), 32'h0);
    step();
    check("z_done_end", 32'(done), 32'h0);
    check("z_valid2", 32'(out_valid), 32'h0);

    // Zero-register force
    rf[0] = 32'h12345678;
`ifdef READ_ZERO_FORCE_EN
    exp_zero = 32'h0;
`else
    exp_zero = 32'h12345678;
`endif
    go(5'd0, 6'd1);
    step();
    check("zf_d", out_data, exp_zero);
    step();
    check("zf_done", 32'(done), 32'h1);
    step();

    // Reset mid-transfer
    out_ready = 1'b0;
    go(5'd4, 6'd3);
    step();
    check("mr_pre_v", 32'(out_valid), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_v",    32'(out_valid), 32'h0);
    check("mr_d",    out_data, 32'h0);
    check("mr_a",    32'(out_addr), 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_ra",   32'(rf_raddr), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mr_nodone", 32'(done), 32'h0);
    end
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();
    check("mr_idle_done", 32'(done), 32'h0);
    go(5'd5, 6'd1);
    step();
    check("mr_d_after", out_data, 32'h53);
    check("mr_a_after", 32'(out_addr), 32'd5);
    step();
    check("mr_done_after", 32'(done), 32'h1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
